// File: rtl/pzbcm_arbiter_pkg.sv
// Shared arbiter definitions: arbiter type encodings, the configuration
// structure driven to an arbiter instance, the default configuration and the
// register map used by the configuration loader.
package pzbcm_arbiter_pkg;

  localparam int PZBCM_ARBITER_MAX_REQUESTS = 16;
  localparam int PRIORITY_WIDTH             = 4;
  localparam int WEIGHT_WIDTH               = 8;
  localparam int INDEX_WIDTH                = $clog2(PZBCM_ARBITER_MAX_REQUESTS);

  // Encodings 6 and 7 are reserved.
  typedef enum logic [2:0] {
    PZBCM_ARBITER_FIXED_PRIORITY       = 3'd0,
    PZBCM_ARBITER_ROUND_ROBIN          = 3'd1,
    PZBCM_ARBITER_WEIGHTED_ROUND_ROBIN = 3'd2,
    PZBCM_ARBITER_PRIORITY_MATRIX      = 3'd3,
    PZBCM_ARBITER_LRU                  = 3'd4,
    PZBCM_ARBITER_INORDER              = 3'd5
  } pzbcm_arbiter_type;

  typedef struct packed {
    logic                                                           reset;
    pzbcm_arbiter_type                                              arbiter_type;
    logic                                                           weight_valid;
    logic [PZBCM_ARBITER_MAX_REQUESTS-1:0][PRIORITY_WIDTH-1:0]      request_priority;
    logic [PZBCM_ARBITER_MAX_REQUESTS-1:0][WEIGHT_WIDTH-1:0]        weight;
    logic [PZBCM_ARBITER_MAX_REQUESTS-1:0][PZBCM_ARBITER_MAX_REQUESTS-1:0] priority_matrix;
  } pzbcm_arbiter_config;

  localparam pzbcm_arbiter_config PZBCM_ARBITER_CONFIG_ROUND_ROBIN = '{
    reset:            1'b0,
    arbiter_type:     PZBCM_ARBITER_ROUND_ROBIN,
    weight_valid:     1'b0,
    request_priority: '0,
    weight:           '0,
    priority_matrix:  '0
  };

  // Register map. Per-requester blocks are PZBCM_ARBITER_MAX_REQUESTS wide.
  localparam logic [7:0] PZBCM_ARBITER_CONFIG_ADDRESS_TYPE         = 8'h00;
  localparam logic [7:0] PZBCM_ARBITER_CONFIG_ADDRESS_WEIGHT_VALID = 8'h01;
  localparam logic [7:0] PZBCM_ARBITER_CONFIG_ADDRESS_COMMIT       = 8'h02;
  localparam logic [7:0] PZBCM_ARBITER_CONFIG_ADDRESS_PRIORITY     = 8'h10;
  localparam logic [7:0] PZBCM_ARBITER_CONFIG_ADDRESS_WEIGHT       = 8'h30;
  localparam logic [7:0] PZBCM_ARBITER_CONFIG_ADDRESS_MATRIX       = 8'h50;

  function automatic logic pzbcm_arbiter_type_is_valid(input logic [2:0] type_code);
    return type_code <= 3'd5;
  endfunction

endpackage

// File: rtl/pzbcm_arbiter_config_shadow.sv
// Shadow register file of the arbiter configuration loader.
// Decodes single-beat CSR writes, updates the shadow configuration and flags
// rejected writes (unmapped address, requester index out of range, reserved
// arbiter type).
//   clk, rst        clock, synchronous active-high reset
//   write_accept    a CSR write transfers this cycle
//   write_address   register address
//   write_data      write data (LSBs used)
//   shadow          shadow configuration (reset field unused)
//   commit_request  accepted COMMIT write with data[0]=1 (combinational)
//   write_error     one-cycle pulse the cycle after a rejected write
module pzbcm_arbiter_config_shadow
  import pzbcm_arbiter_pkg::*;
#(
  parameter int                  REQUESTS       = 4,
  parameter pzbcm_arbiter_config DEFAULT_CONFIG = PZBCM_ARBITER_CONFIG_ROUND_ROBIN
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                write_accept,
  input  logic [7:0]          write_address,
  input  logic [31:0]         write_data,
  output pzbcm_arbiter_config shadow,
  output logic                commit_request,
  output logic                write_error
);

  localparam logic [7:0] BLOCK_SIZE     = 8'(PZBCM_ARBITER_MAX_REQUESTS);
  localparam logic [7:0] REQUESTS_LIMIT = 8'(REQUESTS);

  typedef enum logic [2:0] {
    TARGET_NONE,
    TARGET_TYPE,
    TARGET_WEIGHT_VALID,
    TARGET_COMMIT,
    TARGET_PRIORITY,
    TARGET_WEIGHT,
    TARGET_MATRIX
  } target_e;

  target_e                               target;
  logic [7:0]                            offset;
  logic [INDEX_WIDTH-1:0]                index;
  logic                                  reject;
  logic [PZBCM_ARBITER_MAX_REQUESTS-1:0] matrix_row;
  pzbcm_arbiter_config                   shadow_q;
  logic                                  write_error_q;
  logic                                  unused_data;

  assign unused_data = ^write_data[31:8];

  always_comb begin
    target     = TARGET_NONE;
    offset     = '0;
    matrix_row = '0;
    matrix_row[REQUESTS-1:0] = write_data[REQUESTS-1:0];
    if (write_address == PZBCM_ARBITER_CONFIG_ADDRESS_TYPE) begin
      target = TARGET_TYPE;
    end else if (write_address == PZBCM_ARBITER_CONFIG_ADDRESS_WEIGHT_VALID) begin
      target = TARGET_WEIGHT_VALID;
    end else if (write_address == PZBCM_ARBITER_CONFIG_ADDRESS_COMMIT) begin
      target = TARGET_COMMIT;
    end else if ((write_address >= PZBCM_ARBITER_CONFIG_ADDRESS_PRIORITY) &&
                 (write_address <  PZBCM_ARBITER_CONFIG_ADDRESS_PRIORITY + BLOCK_SIZE)) begin
      target = TARGET_PRIORITY;
      offset = write_address - PZBCM_ARBITER_CONFIG_ADDRESS_PRIORITY;
    end else if ((write_address >= PZBCM_ARBITER_CONFIG_ADDRESS_WEIGHT) &&
                 (write_address <  PZBCM_ARBITER_CONFIG_ADDRESS_WEIGHT + BLOCK_SIZE)) begin
      target = TARGET_WEIGHT;
      offset = write_address - PZBCM_ARBITER_CONFIG_ADDRESS_WEIGHT;
    end else if ((write_address >= PZBCM_ARBITER_CONFIG_ADDRESS_MATRIX) &&
                 (write_address <  PZBCM_ARBITER_CONFIG_ADDRESS_MATRIX + BLOCK_SIZE)) begin
      target = TARGET_MATRIX;
      offset = write_address - PZBCM_ARBITER_CONFIG_ADDRESS_MATRIX;
    end
    index = offset[INDEX_WIDTH-1:0];

    // Per-requester blocks are sized for the maximum requester count, so an
    // in-block address can still name a requester this instance lacks.
    reject = (target == TARGET_NONE) ||
             (((target == TARGET_PRIORITY) || (target == TARGET_WEIGHT) ||
               (target == TARGET_MATRIX)) && (offset >= REQUESTS_LIMIT)) ||
             ((target == TARGET_TYPE) && !pzbcm_arbiter_type_is_valid(write_data[2:0]));
  end

  assign commit_request = write_accept && (target == TARGET_COMMIT) && write_data[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q      <= DEFAULT_CONFIG;
      write_error_q <= 1'b0;
    end else begin
      write_error_q <= write_accept && reject;
      if (write_accept && !reject) begin
        case (target)
          TARGET_TYPE:         shadow_q.arbiter_type            <= pzbcm_arbiter_type'(write_data[2:0]);
          TARGET_WEIGHT_VALID: shadow_q.weight_valid            <= write_data[0];
          TARGET_PRIORITY:     shadow_q.request_priority[index] <= write_data[PRIORITY_WIDTH-1:0];
          TARGET_WEIGHT:       shadow_q.weight[index]           <= write_data[WEIGHT_WIDTH-1:0];
          TARGET_MATRIX:       shadow_q.priority_matrix[index]  <= matrix_row;
          default: ;
        endcase
      end
    end
  end

  assign shadow      = shadow_q;
  assign write_error = write_error_q;

endmodule

// File: rtl/pzbcm_arbiter_config_loader.sv
// Arbiter configuration loader.
// Collects CSR writes into shadow registers and applies them atomically to
// the arbiter configuration on COMMIT, once the arbiter reports idle. Every
// apply (and reset) drives config.reset for one cycle so the arbiter
// reinitialises its rotation/LRU state.
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_write_valid    write request; o_write_ready accepts it
//   i_write_address  register address
//   i_write_data     write data
//   i_arbiter_idle   arbiter has nothing in flight
//   o_config         configuration driven to the arbiter
//   o_busy           commit pending or being applied
//   o_write_error    pulse: an accepted write was rejected
//   o_commit_done    pulse: first cycle a committed config is driven
module pzbcm_arbiter_config_loader
  import pzbcm_arbiter_pkg::*;
#(
  parameter int                  REQUESTS       = 4,
  parameter pzbcm_arbiter_config DEFAULT_CONFIG = PZBCM_ARBITER_CONFIG_ROUND_ROBIN
)(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_write_valid,
  output logic                o_write_ready,
  input  logic [7:0]          i_write_address,
  input  logic [31:0]         i_write_data,
  input  logic                i_arbiter_idle,
  output pzbcm_arbiter_config o_config,
  output logic                o_busy,
  output logic                o_write_error,
  output logic                o_commit_done
);

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    APPLY
  } state_e;

  state_e              state;
  state_e              state_next;
  logic                write_accept;
  logic                commit_request;
  pzbcm_arbiter_config shadow;
  pzbcm_arbiter_config config_q;
  logic                commit_done_q;

  // Entries and matrix columns beyond REQUESTS are forced to zero so the
  // arbiter never sees stale defaults for requesters it does not have.
  function automatic pzbcm_arbiter_config mask_config(input pzbcm_arbiter_config cfg,
                                                      input logic reset_bit);
    pzbcm_arbiter_config masked;
    masked       = cfg;
    masked.reset = reset_bit;
    for (int n = 0; n < PZBCM_ARBITER_MAX_REQUESTS; n++) begin
      if (n >= REQUESTS) begin
        masked.request_priority[n] = '0;
        masked.weight[n]           = '0;
        masked.priority_matrix[n]  = '0;
      end else begin
        for (int b = REQUESTS; b < PZBCM_ARBITER_MAX_REQUESTS; b++) begin
          masked.priority_matrix[n][b] = 1'b0;
        end
      end
    end
    return masked;
  endfunction

  assign o_write_ready = (state == IDLE);
  assign o_busy        = (state != IDLE);
  assign write_accept  = i_write_valid && o_write_ready;

  pzbcm_arbiter_config_shadow #(
    .REQUESTS       (REQUESTS),
    .DEFAULT_CONFIG (DEFAULT_CONFIG)
  ) u_shadow (
    .clk            (i_clk),
    .rst            (i_rst),
    .write_accept   (write_accept),
    .write_address  (i_write_address),
    .write_data     (i_write_data),
    .shadow         (shadow),
    .commit_request (commit_request),
    .write_error    (o_write_error)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (commit_request) state_next = PENDING;
      PENDING: if (i_arbiter_idle) state_next = APPLY;
      APPLY:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Config only reloads on PENDING->APPLY; every other cycle just drops the
  // one-cycle reset strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      config_q      <= mask_config(DEFAULT_CONFIG, 1'b1);
      commit_done_q <= 1'b0;
    end else begin
      commit_done_q <= 1'b0;
      if ((state == PENDING) && i_arbiter_idle) begin
        config_q      <= mask_config(shadow, 1'b1);
        commit_done_q <= 1'b1;
      end else begin
        config_q.reset <= 1'b0;
      end
    end
  end

  assign o_config      = config_q;
  assign o_commit_done = commit_done_q;

endmodule

// File: tb/tb_pzbcm_arbiter_config_loader.sv
module tb_pzbcm_arbiter_config_loader;
  import pzbcm_arbiter_pkg::*;

  localparam int REQUESTS = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                write_valid;
  logic                write_ready;
  logic [7:0]          write_address;
  logic [31:0]         write_data;
  logic                arbiter_idle;
  pzbcm_arbiter_config config_out;
  logic                busy;
  logic                write_error;
  logic                commit_done;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pzbcm_arbiter_config_loader #(
    .REQUESTS       (REQUESTS),
    .DEFAULT_CONFIG (PZBCM_ARBITER_CONFIG_ROUND_ROBIN)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_write_valid   (write_valid),
    .o_write_ready   (write_ready),
    .i_write_address (write_address),
    .i_write_data    (write_data),
    .i_arbiter_idle  (arbiter_idle),
    .o_config        (config_out),
    .o_busy          (busy),
    .o_write_error   (write_error),
    .o_commit_done   (commit_done)
  );

  // Reference model: shadow (s_*) and applied (a_*) register values.
  logic [31:0] s_type, s_wv, a_type, a_wv;
  logic [31:0] s_prio[REQUESTS], s_weight[REQUESTS], s_matrix[REQUESTS];
  logic [31:0] a_prio[REQUESTS], a_weight[REQUESTS], a_matrix[REQUESTS];

  function automatic void model_reset();
    s_type = 1; s_wv = 0; a_type = 1; a_wv = 0;
    for (int n = 0; n < REQUESTS; n++) begin
      s_prio[n] = 0; s_weight[n] = 0; s_matrix[n] = 0;
      a_prio[n] = 0; a_weight[n] = 0; a_matrix[n] = 0;
    end
  endfunction

  function automatic void model_commit();
    a_type = s_type; a_wv = s_wv;
    for (int n = 0; n < REQUESTS; n++) begin
      a_prio[n] = s_prio[n]; a_weight[n] = s_weight[n]; a_matrix[n] = s_matrix[n];
    end
  endfunction

  // Returns 1 when the write must be rejected.
  function automatic bit model_write(input int addr, input logic [31:0] data);
    if (addr == 0) begin
      if ((data & 7) >= 6) return 1;
      s_type = data & 7;
      return 0;
    end
    if (addr == 1) begin s_wv = data & 1; return 0; end
    if (addr == 2) return 0;
    if (addr >= 'h10 && addr < 'h10 + REQUESTS) begin s_prio[addr - 'h10] = data % 16; return 0; end
    if (addr >= 'h30 && addr < 'h30 + REQUESTS) begin s_weight[addr - 'h30] = data % 256; return 0; end
    if (addr >= 'h50 && addr < 'h50 + REQUESTS) begin
      s_matrix[addr - 'h50] = data % (1 << REQUESTS);
      return 0;
    end
    return 1;
  endfunction

  function automatic pzbcm_arbiter_config expected_config(input bit reset_bit);
    pzbcm_arbiter_config cfg;
    cfg              = '0;
    cfg.reset        = reset_bit;
    cfg.arbiter_type = pzbcm_arbiter_type'(a_type[2:0]);
    cfg.weight_valid = a_wv[0];
    for (int n = 0; n < REQUESTS; n++) begin
      cfg.request_priority[n] = a_prio[n][PRIORITY_WIDTH-1:0];
      cfg.weight[n]           = a_weight[n][WEIGHT_WIDTH-1:0];
      cfg.priority_matrix[n]  = '0;
      cfg.priority_matrix[n][REQUESTS-1:0] = a_matrix[n][REQUESTS-1:0];
    end
    return cfg;
  endfunction

  // Drivers (called at a negedge, return at a negedge).
  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, output logic err);
    write_valid = 1'b1; write_address = addr; write_data = data;
    @(posedge clk);
    @(negedge clk);
    write_valid = 1'b0;
    err = write_error;
  endtask

  task automatic run_commit(output pzbcm_arbiter_config cfg_apply, output logic done_apply,
                            output logic busy_pend, output pzbcm_arbiter_config cfg_after,
                            output logic ready_after);
    arbiter_idle = 1'b1;
    write_valid = 1'b1; write_address = 8'h02; write_data = 32'h1;
    @(posedge clk);
    @(negedge clk);
    write_valid = 1'b0;
    busy_pend = busy;
    @(negedge clk);
    cfg_apply = config_out; done_apply = commit_done;
    @(negedge clk);
    cfg_after = config_out; ready_after = write_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1; write_valid = 1'b0; write_address = '0; write_data = '0; arbiter_idle = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if (config_out !== expected_config(1) || busy !== 1'b0 || write_error !== 1'b0 || commit_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: config=%h busy=%b err=%b done=%b required config=%h busy=0 err=0 done=0",
               config_out, busy, write_error, commit_done, expected_config(1));
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (config_out.reset !== 1'b1 || write_ready !== 1'b1 || config_out.arbiter_type !== PZBCM_ARBITER_ROUND_ROBIN) begin
      miscompares++;
      $display("FAIL reset_release: cfg.reset=%b ready=%b type=%0d required 1 1 1",
               config_out.reset, write_ready, config_out.arbiter_type);
    end
    @(negedge clk);
    vectors++;
    if (config_out !== expected_config(0) || write_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_strobe_end: config=%h ready=%b required config=%h ready=1",
               config_out, write_ready, expected_config(0));
    end
  endtask

  task automatic test_commit_lru();
    logic err, done_apply, busy_pend, ready_after;
    pzbcm_arbiter_config cfg_apply, cfg_after;
    do_write(8'h00, 32'd4, err);
    void'(model_write('h00, 32'd4));
    do_write(8'h50, 32'h0E, err);
    void'(model_write('h50, 32'h0E));
    vectors++;
    if (config_out !== expected_config(0) || err !== 1'b0) begin
      miscompares++;
      $display("FAIL lru_no_leak: config=%h err=%b required config=%h err=0", config_out, err, expected_config(0));
    end
    run_commit(cfg_apply, done_apply, busy_pend, cfg_after, ready_after);
    model_commit();
    vectors++;
    if (cfg_apply !== expected_config(1) || done_apply !== 1'b1 || busy_pend !== 1'b1 ||
        cfg_apply.arbiter_type !== PZBCM_ARBITER_LRU || cfg_apply.priority_matrix[0] !== 16'h000E) begin
      miscompares++;
      $display("FAIL lru_apply: config=%h done=%b busy=%b required config=%h done=1 busy=1",
               cfg_apply, done_apply, busy_pend, expected_config(1));
    end
    vectors++;
    if (cfg_after !== expected_config(0) || ready_after !== 1'b1 || commit_done !== 1'b0) begin
      miscompares++;
      $display("FAIL lru_after: config=%h ready=%b done=%b required config=%h ready=1 done=0",
               cfg_after, ready_after, commit_done, expected_config(0));
    end
  endtask

  task automatic test_commit_wait();
    logic err;
    int bad;
    do_write(8'h31, 32'h5A, err);
    void'(model_write('h31, 32'h5A));
    arbiter_idle = 1'b0;
    write_valid = 1'b1; write_address = 8'h02; write_data = 32'h1;
    @(posedge clk);
    @(negedge clk);
    write_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy !== 1'b1 || write_ready !== 1'b0 || commit_done !== 1'b0 || config_out !== expected_config(0)) bad++;
      @(negedge clk);
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL wait_pending: %0d of 10 cycles wrong (busy=%b ready=%b) required busy=1 ready=0 config held",
               bad, busy, write_ready);
    end
    arbiter_idle = 1'b1;
    @(negedge clk);
    model_commit();
    vectors++;
    if (config_out !== expected_config(1) || commit_done !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_apply: config=%h done=%b required config=%h done=1",
               config_out, commit_done, expected_config(1));
    end
    @(negedge clk);
    vectors++;
    if (write_ready !== 1'b1 || busy !== 1'b0 || config_out.reset !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_idle: ready=%b busy=%b reset=%b required 1 0 0", write_ready, busy, config_out.reset);
    end
  endtask

  task automatic test_errors();
    logic err, done_apply, busy_pend, ready_after;
    pzbcm_arbiter_config cfg_apply, cfg_after;
    logic [7:0]  addrs[3] = '{8'h14, 8'h7F, 8'h00};
    logic [31:0] datas[3] = '{32'h3, 32'h1, 32'h7};
    for (int i = 0; i < 3; i++) begin
      bit exp_err;
      exp_err = model_write(int'(addrs[i]), datas[i]);
      vectors++;
      if (write_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL error_ready[%0d]: ready=%b required 1", i, write_ready);
      end
      do_write(addrs[i], datas[i], err);
      vectors++;
      if (err !== exp_err || exp_err !== 1'b1) begin
        miscompares++;
        $display("FAIL error_pulse[%0h]: err=%b required 1", addrs[i], err);
      end
    end
    @(negedge clk);
    vectors++;
    if (write_error !== 1'b0) begin
      miscompares++;
      $display("FAIL error_one_cycle: err=%b required 0", write_error);
    end
    run_commit(cfg_apply, done_apply, busy_pend, cfg_after, ready_after);
    model_commit();
    vectors++;
    if (cfg_apply !== expected_config(1) || done_apply !== 1'b1) begin
      miscompares++;
      $display("FAIL error_shadow: config=%h required %h", cfg_apply, expected_config(1));
    end
  endtask

  task automatic test_weight_truncate();
    logic err, done_apply, busy_pend, ready_after;
    pzbcm_arbiter_config cfg_apply, cfg_after;
    do_write(8'h30, 32'h1FF, err);
    void'(model_write('h30, 32'h1FF));
    run_commit(cfg_apply, done_apply, busy_pend, cfg_after, ready_after);
    model_commit();
    vectors++;
    if (cfg_apply.weight[0] !== 8'hFF || cfg_apply !== expected_config(1) || err !== 1'b0) begin
      miscompares++;
      $display("FAIL weight_truncate: weight0=%h err=%b required weight0=ff err=0", cfg_apply.weight[0], err);
    end
  endtask

  task automatic test_reset_pending();
    logic err;
    do_write(8'h00, 32'd2, err);
    arbiter_idle = 1'b0;
    write_valid = 1'b1; write_address = 8'h02; write_data = 32'h1;
    @(posedge clk);
    @(negedge clk);
    write_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    vectors++;
    if (config_out !== expected_config(1) || commit_done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pending: config=%h done=%b busy=%b required config=%h done=0 busy=0",
               config_out, commit_done, busy, expected_config(1));
    end
    rst = 1'b0;
    arbiter_idle = 1'b1;
    #1;
    vectors++;
    if (write_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_pending_ready: ready=%b required 1", write_ready);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (config_out !== expected_config(0) || commit_done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pending_after: config=%h done=%b required config=%h done=0",
               config_out, commit_done, expected_config(0));
    end
  endtask

  task automatic test_random();
    logic err, done_apply, busy_pend, ready_after;
    pzbcm_arbiter_config cfg_apply, cfg_after;
    for (int i = 0; i < 60; i++) begin
      logic [7:0]  addr;
      logic [31:0] data;
      bit          exp_err;
      case ($urandom_range(0, 5))
        0: addr = 8'h00;
        1: addr = 8'h01;
        2: addr = 8'h10 + 8'($urandom_range(0, 5));
        3: addr = 8'h30 + 8'($urandom_range(0, 5));
        4: addr = 8'h50 + 8'($urandom_range(0, 5));
        default: addr = 8'($urandom_range(0, 255));
      endcase
      if (addr == 8'h02) addr = 8'h03;
      data = $urandom;
      exp_err = model_write(int'(addr), data);
      do_write(addr, data, err);
      vectors++;
      if (err !== exp_err) begin
        miscompares++;
        $display("FAIL random_err[%0d] addr=%h data=%h: err=%b required %b", i, addr, data, err, exp_err);
      end
      if (i % 6 == 5) begin
        run_commit(cfg_apply, done_apply, busy_pend, cfg_after, ready_after);
        model_commit();
        vectors++;
        if (cfg_apply !== expected_config(1) || done_apply !== 1'b1 || cfg_after !== expected_config(0)) begin
          miscompares++;
          $display("FAIL random_commit[%0d]: config=%h done=%b required config=%h done=1",
                   i, cfg_apply, done_apply, expected_config(1));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    write_valid = 1'b0; write_address = '0; write_data = '0; arbiter_idle = 1'b1;
    @(negedge clk);
    test_reset();
    test_commit_lru();
    test_commit_wait();
    test_errors();
    test_weight_truncate();
    test_reset_pending();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pzbcm_arbiter_config_loader.md
# pzbcm_arbiter_config_loader

Producer side of the arbiter configuration interface: it accepts single-beat register writes from a CSR bus and drives a `pzbcm_arbiter_config` to one arbiter instance. Writes land in shadow registers; a COMMIT command applies the whole configuration atomically, but only while the arbiter reports idle. Each apply emits a one-cycle `reset` on the config so the arbiter reinitialises its rotation and LRU state.

## Interface
- `REQUESTS`, default 4: number of arbiter requesters, 2..`PZBCM_ARBITER_MAX_REQUESTS`.
- `DEFAULT_CONFIG`, default `PZBCM_ARBITER_CONFIG_ROUND_ROBIN`: value of the shadow registers and `o_config` at reset.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_write_valid`  in  1  write request.
- `o_write_ready`  out  1  write accept; a write transfers when valid and ready are both high.
- `i_write_address`  in  8  register address.
- `i_write_data`  in  32  write data; only LSBs are used.
- `i_arbiter_idle`  in  1  arbiter has no request or grant in flight.
- `o_config`  out  `$bits(pzbcm_arbiter_config)`  configuration driven to the arbiter.
- `o_busy`  out  1  a commit is pending or being applied.
- `o_write_error`  out  1  one-cycle pulse when an accepted write is rejected.
- `o_commit_done`  out  1  one-cycle pulse in the cycle a new config is first driven.

## Operation
- Register map, with n = 0..`REQUESTS`-1:
  - 0x00: `arbiter_type` from data[2:0].
  - 0x01: `weight_valid` from data[0].
  - 0x02: COMMIT; data[0]=1 requests a commit, data[0]=0 is a no-op.
  - 0x10+n: `request_priority[n]` from data[`PRIORITY_WIDTH`-1:0].
  - 0x30+n: `weight[n]` from data[`WEIGHT_WIDTH`-1:0].
  - 0x50+n: `priority_matrix[n]` from data[`REQUESTS`-1:0].
- A write is rejected when:
  - the address is unmapped,
  - the index n is `REQUESTS` or greater, or
  - `arbiter_type` data is 6 or 7.
- A rejected write is still accepted on the bus. Shadow registers are not modified and `o_write_error` pulses 1 the cycle after acceptance.
- Masking on `o_config`:
  - entries with index `REQUESTS` or greater in `request_priority`, `weight` and `priority_matrix` are driven 0;
  - matrix row bits `REQUESTS` or greater are driven 0.
- FSM:
  - IDLE: `o_write_ready`=1. An accepted COMMIT with data[0]=1 moves to PENDING.
  - PENDING: `o_write_ready`=0, `o_busy`=1. When `i_arbiter_idle`=1, load `o_config` from the shadow registers with `reset`=1 and move to APPLY.
  - APPLY: `o_write_ready`=0, `o_busy`=1, `o_commit_done`=1, `o_config.reset`=1. Clear `reset` and return to IDLE unconditionally.
- `o_config` changes only on the PENDING→APPLY edge and in reset. Shadow writes made in IDLE never reach the arbiter without a commit.
- Reset:
  - all shadow registers load `DEFAULT_CONFIG`;
  - `o_config` loads `DEFAULT_CONFIG` with `reset`=1;
  - state goes to IDLE;
  - `o_write_ready`=1 from the first cycle after reset;
  - `o_busy`, `o_write_error` and `o_commit_done` are 0.
- Reset asserted mid-commit (PENDING or APPLY) aborts the commit. The commit is lost and the defaults are restored.

## Timing
- Shadow register updates are visible from the cycle after acceptance.
- `o_config.reset` stays 1 through reset and for exactly the first cycle after `i_rst` falls.
- Commit accepted at edge k:
  - PENDING from k.
  - If `i_arbiter_idle`=1 in cycle k→k+1: new `o_config` with `reset`=1 and `o_commit_done`=1 from edge k+1.
  - Back to IDLE (ready=1, `reset`=0) from edge k+2.
- `i_arbiter_idle` low holds PENDING indefinitely; no timeout.
- All outputs are registered except `o_write_ready` and `o_busy`, which decode the state register.

## Structure
- `pzbcm_arbiter_pkg` gains:
  - address constants `PZBCM_ARBITER_CONFIG_ADDRESS_{TYPE,WEIGHT_VALID,COMMIT,PRIORITY,WEIGHT,MATRIX}`;
  - a helper that validates an `arbiter_type` encoding.
- The FSM enum stays local to the module.
- Sub-module `pzbcm_arbiter_config_shadow` holds address decode, the shadow registers and error detection. The top level holds the FSM and the `o_config` register.

## Test plan
- Reset with `DEFAULT_CONFIG`=ROUND_ROBIN → `o_config.arbiter_type`=1, `reset`=1 for exactly one cycle after release, `o_write_ready`=1.
- Write 0x00=4 (LRU), then 0x50=0x0E, then COMMIT with idle=1 → `o_config` unchanged until commit; one cycle after commit acceptance type=LRU, `priority_matrix[0]`=0x0E, `reset`=1 and `o_commit_done`=1 for one cycle.
- COMMIT with idle=0 for 10 cycles → `o_busy`=1 and ready=0 throughout, `o_config` unchanged; idle→1 applies the commit next edge.
- Writes to 0x14 (n=4 ≥ `REQUESTS`=4), 0x7F, and 0x00=7 → each accepted with an `o_write_error` pulse; subsequent commit shows shadow unchanged.
- Write 0x30=0x1FF with `WEIGHT_WIDTH`=8 → `weight[0]`=0xFF after commit.
- Assert `i_rst` while in PENDING → return to `DEFAULT_CONFIG`, no `o_commit_done`, ready=1 after release.
